uart_autobaud: RTL and testbench

//  Configures uart_rx/uart_tx prescale by measuring a 0x55 sync character on rxd (8N1, LSB first).

---
 rtl/uart_autobaud_pkg.sv | 17 +
 rtl/uart_autobaud_if.sv | 12 +
 rtl/uart_autobaud.sv | 141 ++++++++++++++
 tb/tb_uart_autobaud.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the 0x55 auto-baud detector.
package uart_autobaud_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StHunt,
        StMeasure
    } state_e;

    // 0x55 in 8N1 gives nine alternating intervals: start, d0..d7.
    localparam int unsigned SYNC_INTERVALS = 9;
    localparam int unsigned SPAN_BITS      = 8;
    localparam int unsigned SPAN_SHIFT     = 6;
    localparam int unsigned TOL_SHIFT      = 2;

endpackage

// File: rtl/uart_autobaud_if.sv
// Line input, control and measurement results of the auto-baud detector.
interface uart_autobaud_if;
    logic        rxd;
    logic        enable;
    logic [15:0] prescale;
    logic        locked;
    logic        busy;
    logic        error;

    modport master (output rxd, enable, input prescale, locked, busy, error);
    modport slave  (input rxd, enable, output prescale, locked, busy, error);
endinterface

// File: rtl/uart_autobaud.sv
// Measures a 0x55 sync character on rxd and derives the UART prescale (bit time = prescale*8).
module uart_autobaud
    import uart_autobaud_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH      = 24,
    parameter int unsigned MIN_INTERVAL     = 8,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd1
) (
    input logic            clk,
    input logic            rst,
    uart_autobaud_if.slave bus
);

    localparam int unsigned PW = (COUNT_WIDTH + 1 > 17) ? COUNT_WIDTH + 1 : 17;

    typedef logic [COUNT_WIDTH-1:0] cnt_t;
    localparam cnt_t       CntMax  = '1;
    localparam cnt_t       CntOne  = cnt_t'(1);
    localparam cnt_t       CntMin  = cnt_t'(MIN_INTERVAL);
    localparam cnt_t       CntIdle = cnt_t'(MIN_INTERVAL - 1);
    localparam logic [3:0] SpanIdx = 4'(SPAN_BITS - 1);
    localparam logic [3:0] LastIdx = 4'(SYNC_INTERVALS - 1);

    state_e           state_q, state_d;
    logic             rxd_last_q;
    cnt_t             iv_cnt_q, span_cnt_q;
    cnt_t             first_iv_q, first_iv_d, span_q, span_d;
    logic [3:0]       edge_idx_q, edge_idx_d;
    logic [15:0]      prescale_q, prescale_d;
    logic             locked_q, locked_d, busy_q, error_q, error_d;
    logic             edge_det, fall, span_load;
    cnt_t             first_ref;
    logic [COUNT_WIDTH:0] iv_ext, first_ext, diff;
    logic             tol_ok, too_short, p_ok;
    logic [PW-1:0]    p_full;

    assign edge_det = bus.rxd != rxd_last_q;
    assign fall     = edge_det & ~bus.rxd;

    // Interval 0 is its own reference, so it always passes tolerance.
    assign first_ref = (edge_idx_q == 4'd0) ? iv_cnt_q : first_iv_q;
    assign iv_ext    = {1'b0, iv_cnt_q};
    assign first_ext = {1'b0, first_ref};
    assign diff      = (iv_ext >= first_ext) ? iv_ext - first_ext : first_ext - iv_ext;
    assign tol_ok    = diff <= {1'b0, first_ref >> TOL_SHIFT};
    assign too_short = iv_cnt_q < CntMin;

    // Round span (8 bit times) to the nearest multiple of 64 clocks.
    assign p_full = (PW'(span_q) + PW'(32)) >> SPAN_SHIFT;
    assign p_ok   = (p_full != '0) && (p_full[PW-1:16] == '0);

    always_comb begin
        state_d    = state_q;
        first_iv_d = first_iv_q;
        span_d     = span_q;
        edge_idx_d = edge_idx_q;
        prescale_d = prescale_q;
        locked_d   = locked_q;
        error_d    = 1'b0;
        span_load  = 1'b0;
        if (!bus.enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StArm;
                StArm: begin
                    if (bus.rxd && !edge_det && iv_cnt_q >= CntIdle) state_d = StHunt;
                end
                StHunt: begin
                    if (fall) begin
                        state_d    = StMeasure;
                        edge_idx_d = 4'd0;
                        span_load  = 1'b1;
                    end
                end
                StMeasure: begin
                    if (iv_cnt_q == CntMax) begin
                        error_d = 1'b1;
                        state_d = StArm;
                    end else if (edge_det) begin
                        if (too_short || !tol_ok) begin
                            error_d = 1'b1;
                            state_d = StArm;
                        end else begin
                            if (edge_idx_q == 4'd0) first_iv_d = iv_cnt_q;
                            if (edge_idx_q == SpanIdx) span_d = span_cnt_q;
                            if (edge_idx_q == LastIdx) begin
                                state_d = StArm;
                                if (p_ok) begin
                                    prescale_d = p_full[15:0];
                                    locked_d   = 1'b1;
                                end else begin
                                    error_d = 1'b1;
                                end
                            end else begin
                                edge_idx_d = edge_idx_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rxd_last_q <= 1'b1;
            iv_cnt_q   <= '0;
            span_cnt_q <= '0;
            first_iv_q <= '0;
            span_q     <= '0;
            edge_idx_q <= '0;
            prescale_q <= DEFAULT_PRESCALE;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rxd_last_q <= bus.rxd;
            iv_cnt_q   <= edge_det ? CntOne :
                          (iv_cnt_q == CntMax) ? CntMax : iv_cnt_q + CntOne;
            span_cnt_q <= span_load ? CntOne :
                          (span_cnt_q == CntMax) ? CntMax : span_cnt_q + CntOne;
            first_iv_q <= first_iv_d;
            span_q     <= span_d;
            edge_idx_q <= edge_idx_d;
            prescale_q <= prescale_d;
            locked_q   <= locked_d;
            busy_q     <= state_d != StIdle;
            error_q    <= error_d;
        end
    end

    assign bus.prescale = prescale_q;
    assign bus.locked   = locked_q;
    assign bus.busy     = busy_q;
    assign bus.error    = error_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench: fixed 0x55 vectors, corner sequences and randomized characters vs a model.
module tb_uart_autobaud;

    localparam int MinIv = 8;

    logic clk = 1'b0;
    logic rst;

    uart_autobaud_if bus ();

    uart_autobaud #(
        .COUNT_WIDTH      (12),
        .MIN_INTERVAL     (MinIv),
        .DEFAULT_PRESCALE (16'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          base;
        int          idx;
        int          val;
        bit          exp_err;
        logic [15:0] exp_p;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    int          cur_iv[9];
    logic [15:0] exp_p;
    logic        exp_locked;
    vec_t        vecs[10];

    always @(negedge clk) if (bus.error === 1'b1) err_cnt <= err_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input int base, input int idx, input int val);
        for (int k = 0; k < 9; k++) cur_iv[k] = (k == idx) ? val : base;
    endtask

    // Start bit low, then alternating data bits of 0x55, then stop/idle high.
    task automatic send_char(input int stop_len);
        for (int k = 0; k < 9; k++) hold(k % 2 == 1, cur_iv[k]);
        hold(1'b1, stop_len);
    endtask

    task automatic rearm();
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        hold(1'b1, 20);
    endtask

    task automatic run_and_check(input string tag, input bit exp_err);
        int e0;
        e0 = err_cnt;
        send_char(40);
        check({tag, " error"}, 32'(err_cnt != e0), 32'(exp_err));
        check({tag, " prescale"}, 32'(bus.prescale), 32'(exp_p));
        check({tag, " locked"}, 32'(bus.locked), 32'(exp_locked));
        rearm();
    endtask

    // Reference: every interval >= MinIv and within first/4 of the first; p from 8-bit span.
    function automatic bit model(output int p);
        int  first;
        int  span;
        int  d;
        bit  err;
        first = cur_iv[0];
        span  = 0;
        err   = 1'b0;
        for (int k = 0; k < 9; k++) begin
            d = cur_iv[k] - first;
            if (d < 0) d = -d;
            if (cur_iv[k] < MinIv || d > first / 4 || cur_iv[k] >= 4095) err = 1'b1;
            if (k < 8) span += cur_iv[k];
        end
        p = (span + 32) / 64;
        if (p == 0 || p > 65535) err = 1'b1;
        return err;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int b;
        int j;
        int p;
        int idx;
        bit e;

        vecs[0] = '{80,  -1, 0,   1'b0, 16'd10};
        vecs[1] = '{160, -1, 0,   1'b0, 16'd20};
        vecs[2] = '{80,  4,  101, 1'b1, 16'd20};
        vecs[3] = '{80,  4,  100, 1'b0, 16'd10};
        vecs[4] = '{24,  8,  30,  1'b0, 16'd3};
        vecs[5] = '{24,  8,  31,  1'b1, 16'd3};
        vecs[6] = '{40,  1,  30,  1'b0, 16'd5};
        vecs[7] = '{40,  1,  29,  1'b1, 16'd5};
        vecs[8] = '{7,   -1, 0,   1'b1, 16'd5};
        vecs[9] = '{200, -1, 0,   1'b0, 16'd25};

        rst        = 1'b1;
        bus.rxd    = 1'b1;
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset prescale", 32'(bus.prescale), 32'd1);
        check("reset locked", 32'(bus.locked), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset error", 32'(bus.error), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle busy", 32'(bus.busy), 32'd0);

        // Back-to-back sync characters without leaving the armed state.
        bus.enable = 1'b1;
        hold(1'b1, 20);
        check("armed busy", 32'(bus.busy), 32'd1);
        e0 = err_cnt;
        fill(80, -1, 0);
        send_char(80);
        check("b2b first prescale", 32'(bus.prescale), 32'd10);
        check("b2b first locked", 32'(bus.locked), 32'd1);
        fill(160, -1, 0);
        send_char(40);
        check("b2b second prescale", 32'(bus.prescale), 32'd20);
        check("b2b second locked", 32'(bus.locked), 32'd1);
        check("b2b no error", 32'(err_cnt - e0), 32'd0);
        rearm();

        exp_locked = 1'b1;
        for (int v = 0; v < 10; v++) begin
            fill(vecs[v].base, vecs[v].idx, vecs[v].val);
            exp_p = vecs[v].exp_p;
            run_and_check($sformatf("vec%0d", v), vecs[v].exp_err);
        end

        // Glitch on an idle line is rejected, a following clean character locks.
        e0 = err_cnt;
        hold(1'b0, 3);
        hold(1'b1, 40);
        check("glitch error", 32'(err_cnt - e0), 32'd1);
        check("glitch prescale held", 32'(bus.prescale), 32'd25);
        fill(80, -1, 0);
        exp_p = 16'd10;
        run_and_check("post-glitch", 1'b0);

        // Line stuck low after a start edge saturates the 12-bit interval counter.
        e0 = err_cnt;
        hold(1'b0, 4090);
        check("timeout early", 32'(err_cnt - e0), 32'd0);
        hold(1'b0, 10);
        check("timeout pulse", 32'(err_cnt - e0), 32'd1);
        check("timeout busy", 32'(bus.busy), 32'd1);
        hold(1'b0, 200);
        check("timeout single pulse", 32'(err_cnt - e0), 32'd1);
        hold(1'b1, 40);
        fill(160, -1, 0);
        exp_p = 16'd20;
        run_and_check("post-timeout", 1'b0);

        for (int n = 0; n < 12; n++) begin
            b = int'($urandom_range(150, 12));
            j = b / 8;
            for (int k = 0; k < 9; k++) cur_iv[k] = b - j + int'($urandom_range(2 * j, 0));
            if ($urandom_range(2, 0) == 0) begin
                idx = int'($urandom_range(8, 0));
                cur_iv[idx] = int'($urandom_range(2 * b, 1));
            end
            e = model(p);
            if (!e) begin
                exp_p      = 16'(p);
                exp_locked = 1'b1;
            end
            run_and_check($sformatf("rand%0d", n), e);
        end

        // Dropping enable mid-measurement goes idle quietly.
        e0 = err_cnt;
        hold(1'b0, 80);
        hold(1'b1, 80);
        hold(1'b0, 30);
        bus.enable = 1'b0;
        @(negedge clk);
        check("disable busy", 32'(bus.busy), 32'd0);
        check("disable no error", 32'(err_cnt - e0), 32'd0);
        check("disable prescale held", 32'(bus.prescale), 32'(exp_p));
        check("disable locked held", 32'(bus.locked), 32'd1);
        hold(1'b1, 10);
        bus.enable = 1'b1;
        hold(1'b1, 20);

        // Asynchronous reset in the middle of a measurement.
        hold(1'b0, 80);
        hold(1'b1, 40);
        #2 rst = 1'b1;
        #1;
        check("async rst prescale", 32'(bus.prescale), 32'd1);
        check("async rst locked", 32'(bus.locked), 32'd0);
        check("async rst busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
